// File: rtl/sub31seq.sv
// rtl/sub31seq.sv - digit-serial unsigned subtractor with registered borrow chain
module sub31seq #(
    parameter int WIDTH = 30,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   A,
    input  logic [WIDTH:0]   B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   out,
    output logic             borrow
);

    localparam int NDIG = (WIDTH + DIGIT) / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH:0]   a_r, b_r, dvec, a_sh, b_sh;
    logic [KW-1:0]    k;
    logic             bin, chain, p, accept, last;
    int               idx;

    assign accept = start && (state != RUN);
    assign last   = (k == KW'(NDIG - 1));

    // One digit of the ripple borrow chain; bit positions above WIDTH are skipped.
    always_comb begin
        dvec  = '0;
        chain = bin;
        idx   = 0;
        a_sh  = '0;
        b_sh  = '0;
        p     = 1'b0;
        for (int j = 0; j < DIGIT; j++) begin
            idx = int'(k) * DIGIT + j;
            if (idx <= WIDTH) begin
                a_sh  = a_r >> idx;
                b_sh  = b_r >> idx;
                p     = a_sh[0] ^ b_sh[0];
                dvec  = dvec | ((WIDTH + 1)'(p ^ chain) << idx);
                chain = (~a_sh[0] & b_sh[0]) | (~p & chain);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready = (state != RUN);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            out    <= '0;
            borrow <= 1'b0;
            bin    <= 1'b0;
            k      <= '0;
        end else if (accept) begin
            a_r    <= A;
            b_r    <= B;
            out    <= '0;
            borrow <= 1'b0;
            bin    <= 1'b0;
            k      <= '0;
        end else if (state == RUN) begin
            out <= out | dvec;
            bin <= chain;
            k   <= k + 1'b1;
            if (last) borrow <= chain;
        end
    end

endmodule

// File: tb/tb_sub31seq.sv
// tb/tb_sub31seq.sv - randomized self-checking bench for sub31seq
module tb_sub31seq;

    localparam int NU = 4;
    localparam int DG [NU] = '{8, 1, 4, 31};
    localparam int ND [NU] = '{4, 31, 8, 1};

    logic        clk, rst;
    logic        start_v  [NU];
    logic [30:0] a_v      [NU];
    logic [30:0] b_v      [NU];
    logic        ready_v  [NU];
    logic        busy_v   [NU];
    logic        done_v   [NU];
    logic [30:0] out_v    [NU];
    logic        borrow_v [NU];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        sub31seq #(.WIDTH(30), .DIGIT(DG[g])) dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .A(a_v[g]), .B(b_v[g]),
            .ready(ready_v[g]), .busy(busy_v[g]), .done(done_v[g]),
            .out(out_v[g]), .borrow(borrow_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [30:0] a, input logic [30:0] b);
        logic [31:0] r;
        r = {1'b0, a} - {1'b0, b};
        return {(a < b) ? 1'b1 : 1'b0, r[30:0]};
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or on timeout, lat=-1).
    task automatic run_op(input int u, input logic [30:0] a, input logic [30:0] b,
                          output logic [30:0] o, output logic bw, output int lat, output int busyc);
        start_v[u] = 1'b1;
        a_v[u] = a;
        b_v[u] = b;
        @(negedge clk);
        start_v[u] = 1'b0;
        a_v[u] = $urandom;
        b_v[u] = $urandom;
        lat = 0;
        busyc = 0;
        while (done_v[u] !== 1'b1 && lat < 100) begin
            if (busy_v[u] === 1'b1) busyc++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) lat = -1;
        o = out_v[u];
        bw = borrow_v[u];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int u = 0; u < NU; u++) begin
            start_v[u] = 1'b0;
            a_v[u] = '0;
            b_v[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            checks++;
            if (ready_v[u] !== 1'b1 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 ||
                out_v[u] !== 31'd0 || borrow_v[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset u%0d: rdy=%b busy=%b done=%b out=%h bw=%b, need 1 0 0 0 0",
                         u, ready_v[u], busy_v[u], done_v[u], out_v[u], borrow_v[u]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [30:0] ta [6] = '{31'd5, 31'd0, 31'h100, 31'h7FFFFFFF, 31'h40000000, 31'd0};
        logic [30:0] tb [6] = '{31'd3, 31'd1, 31'h001, 31'h7FFFFFFF, 31'h00000001, 31'h40000000};
        logic [30:0] te [6] = '{31'd2, 31'h7FFFFFFF, 31'h0FF, 31'd0, 31'h3FFFFFFF, 31'h40000000};
        logic        tw [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [30:0] o;
        logic bw;
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            repeat (i % 2) @(negedge clk);
            run_op(0, ta[i], tb[i], o, bw, lat, bc);
            checks++;
            if (o !== te[i] || bw !== tw[i]) begin
                errors++;
                $display("FAIL directed %0d: out=%h bw=%b, need out=%h bw=%b", i, o, bw, te[i], tw[i]);
            end
            checks++;
            if (lat != 4 || bc != 4) begin
                errors++;
                $display("FAIL directed_latency %0d: lat=%0d busy=%0d, need 4 4", i, lat, bc);
            end
        end
        @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b0 || ready_v[0] !== 1'b1 || out_v[0] !== 31'h40000000 || borrow_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold: done=%b rdy=%b out=%h bw=%b, need 0 1 40000000 1",
                     done_v[0], ready_v[0], out_v[0], borrow_v[0]);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        start_v[0] = 1'b1; a_v[0] = 31'd1000; b_v[0] = 31'd1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 31'd7; b_v[0] = 31'd9;
        @(negedge clk);
        start_v[0] = 1'b0;
        lat = 2;
        while (done_v[0] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4 || out_v[0] !== 31'd999 || borrow_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: lat=%0d out=%h bw=%b, need 4 3e7 0", lat, out_v[0], borrow_v[0]);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_v[0] = 1'b1; a_v[0] = 31'd20; b_v[0] = 31'd50;
        @(negedge clk);
        a_v[0] = 31'h1234; b_v[0] = 31'h0034;
        lat = 0;
        while (done_v[0] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4 || out_v[0] !== 31'h7FFFFFE2 || borrow_v[0] !== 1'b1 || ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d out=%h bw=%b rdy=%b, need 4 7fffffe2 1 1",
                     lat, out_v[0], borrow_v[0], ready_v[0]);
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, need 1 0", busy_v[0], done_v[0]);
        end
        lat = 0;
        while (done_v[0] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4 || out_v[0] !== 31'h1200 || borrow_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d out=%h bw=%b, need 4 1200 0", lat, out_v[0], borrow_v[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        logic [30:0] o;
        logic bw;
        int lat, bc, seen;
        start_v[0] = 1'b1; a_v[0] = 31'h7FFFFF00; b_v[0] = 31'h0F;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_v[0] !== 31'd0 || borrow_v[0] !== 1'b0 || ready_v[0] !== 1'b1 ||
            busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: out=%h bw=%b rdy=%b busy=%b done=%b, need 0 0 1 0 0",
                     out_v[0], borrow_v[0], ready_v[0], busy_v[0], done_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: activity=%0d cycles, need 0", seen);
        end
        run_op(0, 31'd10, 31'd3, o, bw, lat, bc);
        checks++;
        if (o !== 31'd7 || bw !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL after_reset: out=%h bw=%b lat=%0d, need 7 0 4", o, bw, lat);
        end
    endtask

    task automatic test_random;
        logic [30:0] a, b, o;
        logic [31:0] e;
        logic bw;
        int lat, bc;
        for (int n = 0; n < 4000; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : 31'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(0, a, b, o, bw, lat, bc);
            e = model(a, b);
            checks++;
            if (o !== e[30:0] || bw !== e[31] || lat != 4) begin
                errors++;
                $display("FAIL random %0d: %h-%h out=%h bw=%b lat=%0d, need %h %b 4",
                         n, a, b, o, bw, lat, e[30:0], e[31]);
            end
        end
    endtask

    task automatic test_digits;
        logic [30:0] a, b;
        logic [31:0] e;
        int got [NU];
        int cyc, pend;
        for (int n = 0; n < 300; n++) begin
            a = (n == 0) ? 31'h40000000 : (n == 1) ? 31'd0 : 31'($urandom);
            b = (n == 0) ? 31'd1 : (n == 1) ? 31'd1 : 31'($urandom);
            e = model(a, b);
            for (int u = 0; u < NU; u++) begin
                start_v[u] = 1'b1; a_v[u] = a; b_v[u] = b; got[u] = 0;
            end
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                start_v[u] = 1'b0; a_v[u] = $urandom; b_v[u] = $urandom;
            end
            cyc = 0;
            pend = NU;
            while (pend > 0 && cyc < 60) begin
                for (int u = 0; u < NU; u++) begin
                    if (got[u] == 0 && done_v[u] === 1'b1) begin
                        got[u] = 1;
                        pend--;
                        checks++;
                        if (out_v[u] !== e[30:0] || borrow_v[u] !== e[31] || cyc != ND[u]) begin
                            errors++;
                            $display("FAIL digit%0d %0d: %h-%h out=%h bw=%b lat=%0d, need %h %b %0d",
                                     DG[u], n, a, b, out_v[u], borrow_v[u], cyc, e[30:0], e[31], ND[u]);
                        end
                    end
                end
                @(negedge clk);
                cyc++;
            end
            for (int u = 0; u < NU; u++) begin
                if (got[u] == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL digit%0d_timeout %0d: no done within 60 cycles", DG[u], n);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_start;
        test_back_to_back;
        test_reset_midrun;
        test_random;
        test_digits;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
